// File: rtl/avalon_master_engine_if.sv
// Avalon-MM bus bundle between the command engine (master) and the
// codec controller slave port, including the slave interrupt line.
// Signals: read/write/chipselect/address/writedata/beginbursttransfer/
// burstcount (master->slave); readdata/waitrequest/irq (slave->master).
interface avalon_master_engine_if #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 8
);
    logic               read;
    logic               write;
    logic               chipselect;
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  writedata;
    logic [DATA_W-1:0]  readdata;
    logic               waitrequest;
    logic               beginbursttransfer;
    logic [BURST_W-1:0] burstcount;
    logic               irq;

    modport master (
        output read, write, chipselect, address, writedata,
        output beginbursttransfer, burstcount,
        input  readdata, waitrequest, irq
    );

    modport slave (
        input  read, write, chipselect, address, writedata,
        input  beginbursttransfer, burstcount,
        output readdata, waitrequest, irq
    );
endinterface

// File: rtl/avalon_master_engine.sv
// Avalon-MM master: runs write / read / read-modify-write / burst-read
// commands against a slave, with waitrequest timeout and IRQ edge pulse.
// Ports: Clk, Rst_n; cmd_* command handshake; rsp_* response strobe;
// slave (bus interface, master side); irq_evt rising-edge pulse.
module avalon_master_engine #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int BURST_W  = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_data,
    input  logic [DATA_W-1:0]      cmd_mask,
    input  logic [BURST_W-1:0]     cmd_burst,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_last,
    output logic                   rsp_err,
    avalon_master_engine_if.master slave,
    output logic                   irq_evt
);
    localparam int WAIT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RMW_RD, S_RMW_WR, S_BRD
    } state_t;

    state_t             state_q, state_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               cs_q, cs_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               bbt_q, bbt_d;
    logic [BURST_W-1:0] blen_q, blen_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_last_q, rsp_last_d;
    logic               rsp_err_q, rsp_err_d;
    logic               irq_s1_q, irq_s1_d;
    logic               irq_s2_q, irq_s2_d;
    logic               irq_p_q, irq_p_d;
    logic               irq_evt_q, irq_evt_d;

    logic               active, done, stall, tmo, last_beat, fin;
    logic [BURST_W-1:0] req_len;

    assign active    = read_q | write_q;
    assign done      = active & ~slave.waitrequest;
    assign stall     = active & slave.waitrequest;
    // Timeout fires on the MAX_WAIT-th consecutive stalled cycle.
    assign tmo       = stall && (wait_q == WAIT_W'(MAX_WAIT - 1));
    assign last_beat = (beat_q == blen_q - BURST_W'(1));
    assign req_len   = (cmd_burst == '0) ? BURST_W'(1) : cmd_burst;

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        cs_d        = cs_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        bbt_d       = bbt_q;
        blen_d      = blen_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        data_d      = data_q;
        mask_d      = mask_q;
        rd_d        = rd_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        fin         = 1'b0;

        if (stall) wait_d = wait_q + WAIT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cs_d   = 1'b1;
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    mask_d = cmd_mask;
                    wait_d = '0;
                    beat_d = '0;
                    blen_d = BURST_W'(1);
                    unique case (cmd_op)
                        2'b00: begin
                            write_d = 1'b1;
                            wdata_d = cmd_data;
                            state_d = S_WR;
                        end
                        2'b01: begin
                            read_d  = 1'b1;
                            state_d = S_RD;
                        end
                        2'b10: begin
                            read_d  = 1'b1;
                            state_d = S_RMW_RD;
                        end
                        default: begin
                            read_d  = 1'b1;
                            bbt_d   = 1'b1;
                            blen_d  = req_len;
                            state_d = S_BRD;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (done) begin
                    fin        = 1'b1;
                    rsp_data_d = '0;
                end
            end
            S_RD: begin
                if (done) begin
                    fin        = 1'b1;
                    rsp_data_d = slave.readdata;
                end
            end
            S_RMW_RD: begin
                if (done) begin
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    wdata_d = (slave.readdata & ~mask_q) | (data_q & mask_q);
                    rd_d    = slave.readdata;
                    wait_d  = '0;
                    state_d = S_RMW_WR;
                end
            end
            S_RMW_WR: begin
                if (done) begin
                    fin        = 1'b1;
                    rsp_data_d = rd_q;
                end
            end
            S_BRD: begin
                bbt_d = 1'b0;
                if (done) begin
                    wait_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = slave.readdata;
                    rsp_last_d  = last_beat;
                    rsp_err_d   = 1'b0;
                    if (last_beat) fin = 1'b1;
                    else beat_d = beat_q + BURST_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b0;
        end

        // A stalled request that times out abandons the command; in the
        // RMW read phase this also means the write never happens.
        if (tmo) begin
            fin         = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
        end

        if (fin) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            cs_d    = 1'b0;
            bbt_d   = 1'b0;
            blen_d  = '0;
            addr_d  = '0;
            wdata_d = '0;
            wait_d  = '0;
            state_d = S_IDLE;
        end
    end

    // Two-flop synchroniser, then a delay flop for edge detection and a
    // registered pulse: the event appears 3 clocks after the raw edge.
    always_comb begin
        irq_s1_d  = slave.irq;
        irq_s2_d  = irq_s1_q;
        irq_p_d   = irq_s2_q;
        irq_evt_d = irq_s2_q & ~irq_p_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            cs_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bbt_q       <= 1'b0;
            blen_q      <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            irq_s1_q    <= 1'b0;
            irq_s2_q    <= 1'b0;
            irq_p_q     <= 1'b0;
            irq_evt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bbt_q       <= bbt_d;
            blen_q      <= blen_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            irq_s1_q    <= irq_s1_d;
            irq_s2_q    <= irq_s2_d;
            irq_p_q     <= irq_p_d;
            irq_evt_q   <= irq_evt_d;
        end
    end

    assign cmd_ready                = (state_q == S_IDLE);
    assign rsp_valid                = rsp_valid_q;
    assign rsp_data                 = rsp_data_q;
    assign rsp_last                 = rsp_last_q;
    assign rsp_err                  = rsp_err_q;
    assign slave.read               = read_q;
    assign slave.write              = write_q;
    assign slave.chipselect         = cs_q;
    assign slave.address            = addr_q;
    assign slave.writedata          = wdata_q;
    assign slave.beginbursttransfer = bbt_q;
    assign slave.burstcount         = blen_q;
    assign irq_evt                  = irq_evt_q;
endmodule

// File: tb/tb_avalon_master_engine.sv
// Scoreboard bench for avalon_master_engine: reference model predicts
// responses and bus writes; a negedge process acts as slave and monitor.
module tb_avalon_master_engine;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int MW = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [2:0]  a;
        logic [31:0] d;
    } wr_t;

    logic          Clk;
    logic          Rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] cmd_mask;
    logic [BW-1:0] cmd_burst;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_err;
    logic          irq_evt;

    avalon_master_engine_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) slv ();

    avalon_master_engine #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MAX_WAIT(MW)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_mask(cmd_mask), .cmd_burst(cmd_burst),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .slave(slv), .irq_evt(irq_evt)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit chk_lat = 0;
    int rsp_cnt = 0;
    int evt_cnt = 0;
    int irq_rise_cyc = -1;
    int bbt_cnt = 0;
    int wr_cyc_cnt = 0;
    bit s_stuck = 0;
    bit s_rnd = 0;
    int s_fixn = 0;
    int s_fixb = -1;
    int s_run = 0;
    int s_idx = 0;
    int cur_blen = 0;
    logic [31:0] smem [8];
    logic [31:0] shadow [8];
    rsp_t exp_q [$];
    wr_t  wr_q [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic rsp_t mk(input logic [31:0] d, input logic l,
                                input logic e);
        rsp_t r;
        r.data = d;
        r.last = l;
        r.err  = e;
        return r;
    endfunction

    function automatic wr_t mkw(input logic [2:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        return w;
    endfunction

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    // Slave model and response/IRQ monitor, all sampled on the falling edge.
    initial begin
        rsp_t e;
        wr_t x;
        bit w;
        logic [2:0] ai;
        forever begin
            @(negedge Clk);
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", 64'({rsp_data, rsp_last, rsp_err}), 64'(e));
                    if (chk_lat) begin
                        chk("rsp_latency", 64'(cyc + 1 - acc_cyc), 64'd2);
                        chk_lat = 0;
                    end
                    if (rsp_err) chk("timeout_stalls", 64'(s_run), 64'(MW));
                end
            end
            if (irq_evt) begin
                evt_cnt++;
                if (irq_rise_cyc >= 0)
                    chk("irq_delay", 64'(cyc - irq_rise_cyc), 64'd3);
                irq_rise_cyc = -1;
            end
            if (slv.read || slv.write) begin
                if (slv.beginbursttransfer) bbt_cnt++;
                if (slv.write) wr_cyc_cnt++;
                w = s_stuck
                    || (s_run < s_fixn && (s_fixb < 0 || s_fixb == s_idx))
                    || (s_rnd && s_run < 3 && $urandom_range(0, 2) == 0);
                slv.waitrequest = w;
                if (w) begin
                    s_run++;
                end else begin
                    s_run = 0;
                    if (slv.read) begin
                        ai = slv.address + 3'(s_idx);
                        slv.readdata = smem[ai];
                        if (cur_blen > 0)
                            chk("burstcount", 64'(slv.burstcount), 64'(cur_blen));
                        s_idx++;
                    end
                    if (slv.write) begin
                        if (wr_q.size() == 0) begin
                            chk("wr_unexpected", 64'(slv.write), 64'd0);
                        end else begin
                            x = wr_q.pop_front();
                            chk("wr_beat", 64'({slv.address, slv.writedata}), 64'(x));
                        end
                        smem[slv.address] = slv.writedata;
                    end
                end
            end else begin
                slv.waitrequest = 1'($urandom_range(0, 1));
                slv.readdata = $urandom;
                s_run = 0;
                s_idx = 0;
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk("rsp_drain", 64'(exp_q.size()), 64'd0);
        chk("wr_drain", 64'(wr_q.size()), 64'd0);
    endtask

    // Reference model: predicts every response and bus write of a command
    // straight from the command semantics, then drives the handshake.
    task automatic issue(input logic [1:0] op, input logic [2:0] a,
                         input logic [31:0] d, input logic [31:0] m,
                         input logic [7:0] b, input bit stk, input bit rnd,
                         input int fixn, input int fixb, input bit lat,
                         input bit wait_done);
        int n;
        int bl;
        logic [31:0] nv;
        logic [2:0] ai;
        bl = (b == 8'd0) ? 1 : int'(b);
        if (stk) begin
            exp_q.push_back(mk(32'd0, 1'b1, 1'b1));
        end else begin
            case (op)
                2'd0: begin
                    wr_q.push_back(mkw(a, d));
                    shadow[a] = d;
                    exp_q.push_back(mk(32'd0, 1'b1, 1'b0));
                end
                2'd1: exp_q.push_back(mk(shadow[a], 1'b1, 1'b0));
                2'd2: begin
                    nv = (shadow[a] & ~m) | (d & m);
                    wr_q.push_back(mkw(a, nv));
                    exp_q.push_back(mk(shadow[a], 1'b1, 1'b0));
                    shadow[a] = nv;
                end
                default: begin
                    for (int i = 0; i < bl; i++) begin
                        ai = a + 3'(i);
                        exp_q.push_back(mk(shadow[ai], i == bl - 1, 1'b0));
                    end
                end
            endcase
        end
        s_stuck  = stk;
        s_rnd    = rnd;
        s_fixn   = fixn;
        s_fixb   = fixb;
        cur_blen = (op == 2'd3) ? bl : 0;
        @(negedge Clk);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_mask  = m;
        cmd_burst = b;
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = $urandom;
        acc_cyc   = cyc;
        chk_lat   = lat;
        if (wait_done) wait_drain();
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_rsp"}, 64'({rsp_valid, rsp_data, rsp_last, rsp_err}), 64'd0);
        chk({nm, "_bus"}, 64'({slv.read, slv.write, slv.chipselect, slv.address,
                               slv.beginbursttransfer, slv.burstcount,
                               irq_evt, cmd_ready}), 64'd1);
        chk({nm, "_wdata"}, 64'(slv.writedata), 64'd0);
    endtask

    initial begin
        int w0, b0, e0, r0, n;
        Rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_addr = '0;
        cmd_data = '0;
        cmd_mask = '0;
        cmd_burst = '0;
        slv.waitrequest = 1'b0;
        slv.readdata = '0;
        slv.irq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smem[i] = $urandom;
            shadow[i] = smem[i];
        end
        repeat (3) @(negedge Clk);
        chk_quiet("reset");
        Rst_n = 1'b1;

        // Single write, zero wait: latency and bus-cycle count.
        w0 = wr_cyc_cnt;
        issue(2'd0, 3'd1, 32'h12345678, 32'd0, 8'd0, 0, 0, 0, -1, 1, 1);
        chk("wr_cycles", 64'(wr_cyc_cnt - w0), 64'd1);

        // RMW with 3 stall cycles in each phase.
        smem[0] = 32'hAB000000;
        shadow[0] = 32'hAB000000;
        issue(2'd2, 3'd0, 32'h00123456, 32'h00FFFFFF, 8'd0, 0, 0, 3, -1, 0, 1);
        issue(2'd1, 3'd0, 32'd0, 32'd0, 8'd0, 0, 0, 0, -1, 1, 1);

        // Burst of 4 with beat 2 stalled, IRQ rising edge during it.
        for (int i = 0; i < 4; i++) begin
            smem[4 + i] = 32'h10 + 32'(i);
            shadow[4 + i] = smem[4 + i];
        end
        b0 = bbt_cnt;
        e0 = evt_cnt;
        issue(2'd3, 3'd4, 32'd0, 32'd0, 8'd4, 0, 0, 2, 1, 0, 0);
        @(negedge Clk);
        slv.irq = 1'b1;
        irq_rise_cyc = cyc;
        wait_drain();
        repeat (5) @(negedge Clk);
        chk("bbt_cycles", 64'(bbt_cnt - b0), 64'd1);
        chk("irq_pulses", 64'(evt_cnt - e0), 64'd1);
        e0 = evt_cnt;
        slv.irq = 1'b0;
        repeat (6) @(negedge Clk);
        chk("irq_fall_quiet", 64'(evt_cnt - e0), 64'd0);

        // Timeouts on every op, each followed by a normal command.
        issue(2'd1, 3'd2, 32'd0, 32'd0, 8'd0, 1, 0, 0, -1, 0, 1);
        issue(2'd1, 3'd1, 32'd0, 32'd0, 8'd0, 0, 0, 0, -1, 1, 1);
        issue(2'd2, 3'd3, 32'hFFFF, 32'hFF, 8'd0, 1, 0, 0, -1, 0, 1);
        issue(2'd1, 3'd3, 32'd0, 32'd0, 8'd0, 0, 1, 0, -1, 0, 1);
        issue(2'd0, 3'd5, 32'hDEAD, 32'd0, 8'd0, 1, 0, 0, -1, 0, 1);
        issue(2'd3, 3'd6, 32'd0, 32'd0, 8'd3, 1, 0, 0, -1, 0, 1);
        issue(2'd1, 3'd5, 32'd0, 32'd0, 8'd0, 0, 0, 0, -1, 0, 1);

        // Zero burst length behaves as a single beat.
        b0 = bbt_cnt;
        issue(2'd3, 3'd2, 32'd0, 32'd0, 8'd0, 0, 1, 0, -1, 0, 1);
        chk("bbt_burst0", 64'(bbt_cnt - b0), 64'd1);

        // Reset in the middle of a 4-beat burst.
        r0 = rsp_cnt;
        issue(2'd3, 3'd4, 32'd0, 32'd0, 8'd4, 0, 0, 0, -1, 0, 0);
        n = 0;
        while (rsp_cnt < r0 + 2 && n < 100) begin
            @(posedge Clk);
            n++;
        end
        chk("beats_before_reset", 64'(rsp_cnt - r0), 64'd2);
        #2;
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_quiet("midreset");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        r0 = rsp_cnt;
        repeat (5) @(negedge Clk);
        chk("no_rsp_after_reset", 64'(rsp_cnt - r0), 64'd0);
        issue(2'd0, 3'd3, 32'hCAFEF00D, 32'd0, 8'd0, 0, 0, 0, -1, 1, 1);
        issue(2'd1, 3'd3, 32'd0, 32'd0, 8'd0, 0, 0, 0, -1, 1, 1);

        // Randomised traffic with random stalls and occasional timeouts.
        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, 8'($urandom_range(0, 6)),
                  ($urandom_range(0, 9) == 0), 1, 0, -1, 0, 1);
        end

        repeat (4) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/avalon_master_engine.md
Name: avalon_master_engine

Overview:
Synthesisable, parametrised Avalon-MM master. It executes queued register commands against the codec controller slave port, replacing hand-coded bus sequences. It supports:
- single write and single read,
- hardware read-modify-write (masked field update, e.g. the I2C packet field of I2C_DATA_AUDIO),
- burst read.

It adds a waitrequest timeout with error response, and IRQ edge detection. It sits between the host/sequencer logic and the codec controller slave.

Parameters:
ADDR_W, 3, bus address width
DATA_W, 32, bus data width
BURST_W, 8, burstcount width
MAX_WAIT, 255, consecutive waitrequest cycles before timeout (1..2^16-1)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst_n  in  1  asynchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept a command
cmd_op  in  2  00 write, 01 read, 10 read-modify-write, 11 burst read
cmd_addr  in  ADDR_W  target address
cmd_data  in  DATA_W  write data / RMW field value
cmd_mask  in  DATA_W  RMW bit mask (1 = replace bit)
cmd_burst  in  BURST_W  burst beat count (0 treated as 1)
rsp_valid  out  1  one-cycle response strobe (no backpressure)
rsp_data  out  DATA_W  read word (0 for write acks)
rsp_last  out  1  final response of the command
rsp_err  out  1  timeout flag
slave_read  out  1  bus read
slave_write  out  1  bus write
slave_chipselect  out  1  bus chip select
slave_address  out  ADDR_W  bus address
slave_writedata  out  DATA_W  bus write data
slave_readdata  in  DATA_W  bus read data
slave_waitrequest  in  1  slave stall
slave_beginbursttransfer  out  1  burst start marker
slave_burstcount  out  BURST_W  burst length
slave_irq  in  1  asynchronous slave interrupt
irq_evt  out  1  one-cycle pulse on slave_irq rising edge

Behaviour:
- Reset (Rst_n low, any time, including mid-transfer):
  - All outputs are 0 except cmd_ready, which is 1.
  - FSM goes to IDLE, the wait counter clears, and the IRQ synchronisers clear.
  - An in-flight command is abandoned with no response.
- FSM states: IDLE, WR, RD, RMW_RD, RMW_WR, BRD.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - A command is accepted on the edge where cmd_valid & cmd_ready. All cmd_* fields are registered at that edge.
  - On that edge the bus outputs assert (registered): chipselect = 1, address = cmd_addr, and read or write per cmd_op.
- Beat acceptance: a bus beat completes in any cycle where (slave_read | slave_write) & !slave_waitrequest. Read data is sampled in that cycle.
- WR: on completion, write and chipselect drop at the next edge. At that edge rsp_valid = 1, rsp_data = 0, rsp_last = 1. The FSM returns to IDLE.
  - Zero-wait latency: accept at edge T, bus active T..T+1, response in cycle T+2, cmd_ready = 1 in cycle T+2.
- RD: identical timing to WR, with rsp_data = the sampled read word.
- RMW_RD → RMW_WR:
  - On read completion, read drops and write asserts at the same edge.
  - writedata = (rd & ~cmd_mask) | (cmd_data & cmd_mask).
  - Chipselect stays high across both phases.
  - After the write completes, one response is issued: rsp_data = original read word, rsp_last = 1.
- BRD:
  - slave_burstcount = max(cmd_burst, 1), held for the whole burst.
  - beginbursttransfer = 1 only in the first bus cycle.
  - read stays high until the final beat completes.
  - Each completed beat produces rsp_valid the following cycle with that word. rsp_last = 1 on the final beat only.
  - An internal beat counter (BURST_W bits) counts up to the burst count; it never wraps.
- Timeout:
  - The wait counter increments each cycle waitrequest stalls an active request, and clears on every completed beat or phase change.
  - When the counter reaches MAX_WAIT, all bus outputs drop at the next edge. That edge issues rsp_valid = 1, rsp_err = 1, rsp_last = 1, rsp_data = 0, and the FSM returns to IDLE.
  - A RMW that times out in its read phase performs no write.
- rsp_err is 0 on every non-timeout response. rsp_* outputs hold their last value when rsp_valid = 0, except rsp_valid itself.
- IRQ path:
  - slave_irq passes through a 2-flop synchroniser plus an edge register.
  - irq_evt = 1 for one cycle, 3 cycles after the rising edge.
  - It is independent of the FSM and never masked by command activity.

Test Plan:
1. Write, op 00, addr 1, data 0x12345678, waitrequest = 0 → bus write for 1 cycle with writedata 0x12345678; response 2 cycles after accept: rsp_data = 0, rsp_last = 1, rsp_err = 0.
2. RMW, addr 0:
   - Stimulus: slave returns 0xAB000000; cmd_data = 0x00123456, mask = 0x00FFFFFF; waitrequest high 3 cycles in each phase.
   - Required: writedata = 0xAB123456; a single response with rsp_data = 0xAB000000.
3. Burst read, cmd_burst = 4, slave returns 0x10..0x13, waitrequest high on beat 2 for 2 cycles → beginbursttransfer for 1 cycle, burstcount = 4 throughout, 4 responses in order, rsp_last only on 0x13.
4. Timeout, MAX_WAIT = 8, waitrequest stuck high on a read → bus drops after 8 stall cycles; rsp_err = 1, rsp_last = 1; the next command is accepted normally.
5. Rst_n pulsed low mid-burst (after beat 2 of 4) → all outputs 0 immediately, cmd_ready = 1, no further responses; a post-reset write completes normally.
6. slave_irq rising edge during a burst → exactly one irq_evt pulse, 3 cycles later; the burst is unaffected. cmd_burst = 0 → treated as a 1-beat burst.
